// File: rtl/cover_pkg.sv
// Shared types for the on-chip toggle-cover collector: index width, FSM states
// and a width helper that keeps encoder outputs at least one bit wide.
package cover_pkg;

    localparam int COVER_IDX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } cov_col_state_e;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

    function automatic int pos_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Combinational lowest-set-bit encoder used to walk the drain snapshot in
// ascending bit order.
module cover_prio_enc
    import cover_pkg::*;
#(
    parameter  int WIDTH = 36,
    localparam int POS_W = pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             found_o,
    output logic [POS_W-1:0] pos_o
);

    // Scan from the top so the last hit written is the lowest set bit.
    always_comb begin
        found_o = 1'b0;
        pos_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                pos_o   = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-hit collector: accumulates per-bit toggle events and drains a
// snapshot of them as ascending global cover indices over valid/ready.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter  int          WIDTH       = 36,
    parameter  int unsigned COVER_INDEX = 0,
    parameter  int unsigned COVER_TOTAL = 10906,
    localparam int          HC_W        = $clog2(WIDTH + 1),
    localparam int          POS_W       = pos_width(WIDTH)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [WIDTH-1:0]       valid_i,
    input  logic                   clear_req_i,
    input  logic                   dump_req_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COVER_IDX_W-1:0] out_index_o,
    output logic                   dump_done_o,
    output logic                   busy_o,
    output logic [HC_W-1:0]        hit_count_o
);

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    cov_col_state_e   state_q, state_d;
    logic [WIDTH-1:0] hits_q, hits_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    cover_idx_t       out_index_q, out_index_d;
    logic [HC_W-1:0]  hit_count_q, hit_count_d;

    logic             enc_found;
    logic [POS_W-1:0] enc_pos;

    cover_prio_enc #(.WIDTH(WIDTH)) u_enc (
        .vec_i   (snap_q),
        .found_o (enc_found),
        .pos_o   (enc_pos)
    );

    always_comb begin
        state_d     = state_q;
        hits_d      = hits_q | valid_i;
        snap_d      = snap_q;
        out_index_d = out_index_q;
        case (state_q)
            IDLE: begin
                // Dump wins over clear; same-cycle events land in both hits and snap.
                if (dump_req_i) begin
                    snap_d  = hits_q | valid_i;
                    state_d = SCAN;
                end else if (clear_req_i) begin
                    hits_d = valid_i;
                end
            end
            SCAN: begin
                if (enc_found) begin
                    out_index_d     = cover_idx_t'(COVER_INDEX) + cover_idx_t'(enc_pos);
                    snap_d[enc_pos] = 1'b0;
                    state_d         = EMIT;
                end else begin
                    state_d = DONE;
                end
            end
            EMIT: begin
                if (out_ready_i) state_d = SCAN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        hit_count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit_count_d = hit_count_d + HC_W'(hits_q[i]);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            hits_q      <= '0;
            snap_q      <= '0;
            out_index_q <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hits_q      <= hits_d;
            snap_q      <= snap_d;
            out_index_q <= out_index_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_valid_o = (state_q == EMIT);
    assign dump_done_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_index_o = out_index_q;
    assign hit_count_o = hit_count_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed plus randomized bench for cover_toggle_collector; two instances with
// different COVER_INDEX share stimulus and are checked against a set-based model.
module tb_cover_toggle_collector;

    localparam int W   = 36;
    localparam int CI0 = 0;
    localparam int CI1 = 10870;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] valid;
    logic         clr, dump, rdy;
    logic         ov0, ov1, dd0, dd1, bz0, bz1;
    logic [63:0]  oi0, oi1;
    logic [5:0]   hc0, hc1;

    cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI0), .COVER_TOTAL(10906)) dut0 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid), .clear_req_i(clr),
        .dump_req_i(dump), .out_valid_o(ov0), .out_ready_i(rdy), .out_index_o(oi0),
        .dump_done_o(dd0), .busy_o(bz0), .hit_count_o(hc0)
    );

    cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI1), .COVER_TOTAL(10906)) dut1 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid), .clear_req_i(clr),
        .dump_req_i(dump), .out_valid_o(ov1), .out_ready_i(rdy), .out_index_o(oi1),
        .dump_done_o(dd1), .busy_o(bz1), .hit_count_o(hc1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: the set of bits ever seen since reset/clear, and its popcount one cycle late.
    logic [W-1:0] m_hits = '0;
    int           m_hc   = 0;
    bit           m_clr_ok = 1'b0;
    int           exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_hits = '0;
            m_hc   = 0;
        end else begin
            m_hc = $countones(m_hits);
            if (m_clr_ok && clr && !dump) m_hits = valid;
            else                          m_hits = m_hits | valid;
        end
        #1;
        valid    = '0;
        clr      = 1'b0;
        dump     = 1'b0;
        m_clr_ok = 1'b0;
        chk("hit_count0", 64'(hc0), 64'(m_hc));
        chk("hit_count1", 64'(hc1), 64'(m_hc));
    endtask

    // Request a dump and drain it; the expected stream is every set bit of the
    // snapshot in ascending order, offset by each instance's COVER_INDEX.
    task automatic do_dump(input logic [W-1:0] v_req, input bit clr_req, input int stall,
                           input logic [W-1:0] v_mid, input bit clr_emit, input bit rnd_rdy,
                           output int cyc);
        logic [W-1:0] snap;
        int  st;
        bit  done, mid_done, acc, ce;
        snap = m_hits | v_req;
        exp_q.delete();
        for (int i = 0; i < W; i++) if (snap[i]) exp_q.push_back(i);
        st = stall; done = 0; mid_done = 0; ce = clr_emit; cyc = 0;
        valid = v_req; clr = clr_req; dump = 1'b1;
        tick();
        chk("busy_after_req", 64'(bz0), 64'd1);
        while (!done && cyc < 400) begin
            if (dd0) begin
                chk("drain_left_at_done", 64'(exp_q.size()), 64'd0);
                chk("dump_done1", 64'(dd1), 64'd1);
                done = 1;
            end else begin
                if (ov0) begin
                    chk("out_valid1", 64'(ov1), 64'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 64'(ov0), 64'd0);
                    end else begin
                        chk("out_index0", oi0, 64'(CI0 + exp_q[0]));
                        chk("out_index1", oi1, 64'(CI1 + exp_q[0]));
                    end
                    if (ce) begin clr = 1'b1; ce = 0; end
                    rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : (st == 0);
                    if (st > 0) st--;
                end
                if (!mid_done) begin valid = v_mid; mid_done = 1; end
                acc = ov0 && rdy;
                tick();
                if (acc && exp_q.size() > 0) void'(exp_q.pop_front());
                cyc++;
            end
        end
        if (!done) chk("dump_timeout", 64'(done), 64'd1);
        tick();
        chk("dump_done_one_cycle", 64'(dd0), 64'd0);
        chk("idle_after_dump", 64'(bz0), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] v, vm;
        logic [31:0]  r;
        rst = 1'b1; valid = '0; clr = 1'b0; dump = 1'b0; rdy = 1'b1;
        tick();
        valid = '1;
        tick();
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_out_index0", oi0, 64'd0);
        chk("rst_out_index1", oi1, 64'd0);
        chk("rst_dump_done", 64'(dd0), 64'd0);
        chk("rst_busy", 64'(bz0), 64'd0);
        rst = 1'b0;

        // Empty dump: done two cycles after request, nothing emitted.
        repeat (10) tick();
        do_dump('0, 0, 0, '0, 0, 0, cyc);
        chk("empty_dump_latency", 64'(cyc), 64'd1);

        // Three separate pulses, then drain 0,5,35.
        valid = W'(1) << 0;  tick();
        valid = W'(1) << 5;  tick();
        valid = W'(1) << 35; tick();
        tick();
        chk("hit_count_three", 64'(hc0), 64'd3);
        do_dump('0, 0, 0, '0, 0, 0, cyc);

        // Clear keeping only bit 35, then stall the consumer for 8 cycles.
        valid = W'(1) << 35; clr = 1'b1; m_clr_ok = 1'b1; tick();
        tick();
        chk("hit_count_after_clear", 64'(hc0), 64'd1);
        do_dump('0, 0, 8, '0, 0, 0, cyc);

        // Event during a dump misses this drain but shows in the next one.
        do_dump('0, 0, 0, W'(1) << 7, 0, 0, cyc);
        do_dump('0, 0, 0, '0, 0, 0, cyc);

        // Clear with a same-cycle event, then a clear during EMIT that must be ignored.
        valid = W'(1) << 3; clr = 1'b1; m_clr_ok = 1'b1; tick();
        tick();
        chk("clear_keeps_same_cycle", 64'(hc0), 64'd1);
        do_dump('0, 0, 0, '0, 1, 0, cyc);
        tick();
        chk("clear_in_emit_ignored", 64'(hc0), 64'd1);

        // Reset while an index is being offered.
        rdy = 1'b0; valid = W'(1) << 2; dump = 1'b1; tick();
        for (int i = 0; i < 6 && !ov0; i++) tick();
        chk("emit_before_reset", 64'(ov0), 64'd1);
        rst = 1'b1; tick();
        chk("reset_drops_valid", 64'(ov0), 64'd0);
        chk("reset_no_done", 64'(dd0), 64'd0);
        chk("reset_not_busy", 64'(bz0), 64'd0);
        rst = 1'b0; rdy = 1'b1; tick();
        chk("reset_no_done_later", 64'(dd0), 64'd0);
        do_dump('0, 0, 0, '0, 0, 0, cyc);
        chk("post_reset_empty_latency", 64'(cyc), 64'd1);

        // Randomized sparse events, occasional idle clears, random consumer stalls.
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 20; c++) begin
                r = $urandom & $urandom & $urandom;
                valid = {4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), r};
                if ($urandom_range(0, 15) == 0) begin clr = 1'b1; m_clr_ok = 1'b1; end
                tick();
            end
            r  = $urandom & $urandom;
            v  = {4'($urandom_range(0, 15)), r};
            r  = $urandom & $urandom;
            vm = {4'($urandom_range(0, 15)), r};
            do_dump(v, 1'($urandom_range(0, 1)), 0, vm, 0, 1, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
